// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: grants one functional unit per cycle into a one-entry output register.
// Optional CONFIG_WB_ARB_RR_EN selects round-robin; default build is fixed priority (lowest index wins).
`timescale 1ns/1ps

package tortoise_pkg;
    typedef struct packed {
        logic        valid;
        logic [7:0]  cause;
        logic [63:0] tval;
    } exception_t;

    typedef struct packed {
        logic [63:0] result;
        logic [3:0]  index;
        exception_t  ex;
    } fu_result_t;
endpackage

module fu_wb_arbiter #(
    parameter int unsigned NR_FU = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  flush_i,
    input  logic [NR_FU-1:0]                      fu_valid_i,
    input  tortoise_pkg::fu_result_t [NR_FU-1:0]  fu_result_i,
    output logic [NR_FU-1:0]                      fu_ready_o,
    output logic                                  wb_valid_o,
    output tortoise_pkg::fu_result_t              wb_result_o,
    output logic [$clog2(NR_FU)-1:0]              wb_src_o,
    input  logic                                  wb_ready_i
);
    localparam int unsigned IDX_W = $clog2(NR_FU);
    typedef logic [IDX_W-1:0] idx_t;

    logic                     out_valid_q;
    tortoise_pkg::fu_result_t out_result_q;
    idx_t                     out_src_q;

    logic       can_load;
    logic       gnt_en;
    logic       gnt_found;
    logic       grant;
    idx_t       gnt_idx;
    idx_t       scan_base;
    logic [IDX_W:0] cand;

`ifdef CONFIG_WB_ARB_RR_EN
    idx_t rr_ptr_q;
    assign scan_base = rr_ptr_q;
`else
    assign scan_base = '0;
`endif

    assign can_load = !out_valid_q || wb_ready_i;
    // Reset also gates the grant so no unit believes its result was consumed.
    assign gnt_en   = rst_ni && !flush_i && can_load;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NR_FU; k++) begin
            cand = {1'b0, scan_base} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NR_FU)) begin
                cand = cand - (IDX_W+1)'(NR_FU);
            end
            if (!gnt_found && fu_valid_i[cand[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign grant      = gnt_en && gnt_found;
    assign fu_ready_o = grant ? (NR_FU'(1) << gnt_idx) : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_src_q    <= '0;
        end else if (flush_i) begin
            out_valid_q  <= 1'b0;
        end else if (grant) begin
            out_valid_q  <= 1'b1;
            out_result_q <= fu_result_i[gnt_idx];
            out_src_q    <= gnt_idx;
        end else if (wb_ready_i) begin
            out_valid_q  <= 1'b0;
        end
    end

`ifdef CONFIG_WB_ARB_RR_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (grant) begin
            rr_ptr_q <= (gnt_idx == idx_t'(NR_FU-1)) ? '0 : gnt_idx + idx_t'(1);
        end
    end
`endif

    assign wb_valid_o  = out_valid_q;
    assign wb_result_o = out_result_q;
    assign wb_src_o    = out_src_q;
endmodule
